// File: rtl/axi_lite_ram_slave.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module   : axi_lite_ram_slave                                            |
// | Brief    : AXI4-Lite slave that turns each transaction into a single     |
// |            Simple_RAM access. Optional macro AXI_RAM_ADDR_CHECK_EN turns  |
// |            out-of-range accesses into SLVERR responses.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module axi_lite_ram_slave #(
    parameter int  DATA_WIDTH_BYTES = 4,
    parameter int  NUM_SLOTS        = 5,
    parameter int  AXI_ADDR_WIDTH   = 32,
    localparam int DATA_WIDTH_BITS  = DATA_WIDTH_BYTES * 8,
    localparam int RAM_ADDR_BITS    = $clog2(NUM_SLOTS),
    localparam int ADDR_LSB         = $clog2(DATA_WIDTH_BYTES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [DATA_WIDTH_BITS-1:0]  s_axi_wdata,
    input  logic [DATA_WIDTH_BYTES-1:0] s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [DATA_WIDTH_BITS-1:0]  s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic                        ram_r_en,
    output logic [RAM_ADDR_BITS-1:0]    ram_r_addr,
    input  logic [DATA_WIDTH_BITS-1:0]  ram_r_data,
    output logic                        ram_w_en,
    output logic [RAM_ADDR_BITS-1:0]    ram_w_addr,
    output logic [DATA_WIDTH_BITS-1:0]  ram_w_data,
    output logic [DATA_WIDTH_BYTES-1:0] ram_w_strb
);

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
`ifdef AXI_RAM_ADDR_CHECK_EN
    localparam bit c_ADDR_CHECK = 1'b1;
`else
    localparam bit c_ADDR_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        W_IDLE   = 2'd0,
        W_ACCESS = 2'd1,
        W_RESP   = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE    = 2'd0,
        R_ACCESS  = 2'd1,
        R_CAPTURE = 2'd2,
        R_RESP    = 2'd3
    } rstate_t;

    function automatic logic [RAM_ADDR_BITS-1:0] f_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return addr[ADDR_LSB +: RAM_ADDR_BITS];
    endfunction

    function automatic logic f_in_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
        logic [RAM_ADDR_BITS:0] w_idx_ext;
        w_idx_ext = {1'b0, addr[ADDR_LSB +: RAM_ADDR_BITS]};
        return (w_idx_ext < (RAM_ADDR_BITS + 1)'(NUM_SLOTS)) &&
               ((addr >> (ADDR_LSB + RAM_ADDR_BITS)) == '0);
    endfunction

    // Byte-offset bits never select anything.
    logic w_unused_addr_lsbs;
    assign w_unused_addr_lsbs = ^{s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

    // ------------------------------------------------------------------ write
    wstate_t                     r_wstate, w_wstate_nxt;
    logic                        r_aw_held, r_w_held;
    logic                        r_awready, r_wready, r_bvalid;
    logic [1:0]                  r_bresp;
    logic                        w_awready_nxt, w_wready_nxt, w_bvalid_nxt;
    logic [1:0]                  w_bresp_nxt;
    logic [RAM_ADDR_BITS-1:0]    r_wr_idx;
    logic                        r_wr_inrange;
    logic [DATA_WIDTH_BITS-1:0]  r_wdata;
    logic [DATA_WIDTH_BYTES-1:0] r_wstrb;
    logic                        w_aw_fire, w_w_fire, w_aw_have, w_w_have, w_ram_w_en;

    assign w_aw_fire  = (r_wstate == W_IDLE) && r_awready && s_axi_awvalid;
    assign w_w_fire   = (r_wstate == W_IDLE) && r_wready && s_axi_wvalid;
    assign w_aw_have  = r_aw_held || w_aw_fire;
    assign w_w_have   = r_w_held || w_w_fire;
    assign w_ram_w_en = (r_wstate == W_ACCESS) && r_wr_inrange;

    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_awready_nxt = 1'b0;
        w_wready_nxt  = 1'b0;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_have && w_w_have) begin
                    w_wstate_nxt = W_ACCESS;
                end else begin
                    w_awready_nxt = !w_aw_have;
                    w_wready_nxt  = !w_w_have;
                end
            end
            W_ACCESS: begin
                w_wstate_nxt = W_RESP;
                w_bvalid_nxt = 1'b1;
                w_bresp_nxt  = (!r_wr_inrange && c_ADDR_CHECK) ? c_RESP_SLVERR : c_RESP_OKAY;
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_wstate_nxt  = W_IDLE;
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                end
            end
            default: begin
                w_wstate_nxt = W_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate     <= W_IDLE;
            r_aw_held    <= 1'b0;
            r_w_held     <= 1'b0;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_bvalid     <= 1'b0;
            r_bresp      <= c_RESP_OKAY;
            r_wr_idx     <= '0;
            r_wr_inrange <= 1'b0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            // Hold flags only matter while idle; clear them once the access starts.
            if (r_wstate != W_IDLE) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
            end else begin
                if (w_aw_fire) r_aw_held <= 1'b1;
                if (w_w_fire)  r_w_held  <= 1'b1;
            end
            if (w_aw_fire) begin
                r_wr_idx     <= f_idx(s_axi_awaddr);
                r_wr_inrange <= f_in_range(s_axi_awaddr);
            end
            if (w_w_fire) begin
                r_wdata <= s_axi_wdata;
                r_wstrb <= s_axi_wstrb;
            end
        end
    end

    // ------------------------------------------------------------------- read
    rstate_t                    r_rstate, w_rstate_nxt;
    logic                       r_arready, r_rvalid;
    logic [1:0]                 r_rresp;
    logic [DATA_WIDTH_BITS-1:0] r_rdata;
    logic                       w_arready_nxt, w_rvalid_nxt;
    logic [1:0]                 w_rresp_nxt;
    logic [DATA_WIDTH_BITS-1:0] w_rdata_nxt;
    logic [RAM_ADDR_BITS-1:0]   r_rd_idx;
    logic                       r_rd_inrange;
    logic                       w_ar_fire, w_collide;

    assign w_ar_fire = (r_rstate == R_IDLE) && r_arready && s_axi_arvalid;
    // A read of the word being written this cycle waits one cycle to see the merged data.
    assign w_collide = (r_rstate == R_ACCESS) && r_rd_inrange && w_ram_w_en &&
                       (r_rd_idx == r_wr_idx);

    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_arready_nxt = 1'b0;
        w_rvalid_nxt  = r_rvalid;
        w_rresp_nxt   = r_rresp;
        w_rdata_nxt   = r_rdata;
        case (r_rstate)
            R_IDLE: begin
                if (w_ar_fire) begin
                    w_rstate_nxt = R_ACCESS;
                end else begin
                    w_arready_nxt = 1'b1;
                end
            end
            R_ACCESS: begin
                if (!w_collide) begin
                    w_rstate_nxt = R_CAPTURE;
                end
            end
            R_CAPTURE: begin
                w_rstate_nxt = R_RESP;
                w_rvalid_nxt = 1'b1;
                w_rdata_nxt  = r_rd_inrange ? ram_r_data : '0;
                w_rresp_nxt  = (!r_rd_inrange && c_ADDR_CHECK) ? c_RESP_SLVERR : c_RESP_OKAY;
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    w_rstate_nxt  = R_IDLE;
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                end
            end
            default: begin
                w_rstate_nxt = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rstate     <= R_IDLE;
            r_arready    <= 1'b0;
            r_rvalid     <= 1'b0;
            r_rresp      <= c_RESP_OKAY;
            r_rdata      <= '0;
            r_rd_idx     <= '0;
            r_rd_inrange <= 1'b0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rresp   <= w_rresp_nxt;
            r_rdata   <= w_rdata_nxt;
            if (w_ar_fire) begin
                r_rd_idx     <= f_idx(s_axi_araddr);
                r_rd_inrange <= f_in_range(s_axi_araddr);
            end
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;

    assign ram_w_en   = w_ram_w_en;
    assign ram_w_addr = r_wr_idx;
    assign ram_w_data = r_wdata;
    assign ram_w_strb = r_wstrb;
    assign ram_r_en   = (r_rstate == R_ACCESS) && r_rd_inrange && !w_collide;
    assign ram_r_addr = r_rd_idx;

endmodule
`default_nettype wire

// File: doc/axi_lite_ram_slave.md
Name: axi_lite_ram_slave

Overview:
- AXI4-Lite slave front-end sitting directly upstream of Simple_RAM.
- Accepts AXI4-Lite read and write transactions and converts each one into a single Simple_RAM access (r_en/r_addr, or w_en/w_addr/w_data/w_strb).
- Returns the matching AXI response.
- Read and write paths are independent FSMs, each with one outstanding transaction.

Parameters:
- DATA_WIDTH_BYTES, 4, data bus width in bytes (matches Simple_RAM).
- NUM_SLOTS, 5, number of RAM words (matches Simple_RAM).
- AXI_ADDR_WIDTH, 32, AXI byte-address width.
- (derived) DATA_WIDTH_BITS = DATA_WIDTH_BYTES*8; RAM_ADDR_BITS = $clog2(NUM_SLOTS); ADDR_LSB = $clog2(DATA_WIDTH_BYTES).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write byte address.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  DATA_WIDTH_BITS  write data.
- s_axi_wstrb  in  DATA_WIDTH_BYTES  byte strobes.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_araddr  in  AXI_ADDR_WIDTH  read byte address.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rdata  out  DATA_WIDTH_BITS  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- ram_r_en, ram_r_addr, ram_r_data  out, out, in  1, RAM_ADDR_BITS, DATA_WIDTH_BITS  Simple_RAM read port.
- ram_w_en, ram_w_addr, ram_w_data, ram_w_strb  out  1, RAM_ADDR_BITS, DATA_WIDTH_BITS, DATA_WIDTH_BYTES  Simple_RAM write port.

Behaviour:
- Reset (rst_n=0, asynchronous)
  - All ready/valid outputs are 0; ram_r_en and ram_w_en are 0.
  - All data, address, resp and strb outputs are 0.
  - Both FSMs go to IDLE.
  - Reset asserted mid-transaction abandons the transaction; no RAM write is issued after reset.
- Address decode
  - idx = addr[ADDR_LSB +: RAM_ADDR_BITS]. Address bits below ADDR_LSB are ignored.
  - The address is in range iff idx < NUM_SLOTS and all bits above ADDR_LSB+RAM_ADDR_BITS are 0.
- Write FSM: W_IDLE -> W_ACCESS -> W_RESP
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. AW and W are captured independently, in either order or in the same cycle; each is held once captured.
  - When both are held, go to W_ACCESS.
  - W_ACCESS (exactly 1 cycle):
    - In range: ram_w_en=1 with idx, wdata and wstrb.
    - Out of range: ram_w_en stays 0.
    - bresp is set: OKAY (2'b00) or SLVERR (2'b10).
  - W_RESP: bvalid=1 until bready=1 is sampled, then return to W_IDLE.
  - Minimum cost is 3 cycles per write.
- Read FSM: R_IDLE -> R_ACCESS -> R_CAPTURE -> R_RESP
  - R_IDLE: arready=1; on the AR handshake, latch the address.
  - R_ACCESS (1 cycle): in range -> ram_r_en=1, ram_r_addr=idx.
  - R_CAPTURE: Simple_RAM read data is valid one cycle after r_en.
    - In range: s_axi_rdata <= ram_r_data.
    - Out of range: s_axi_rdata <= 0, rresp=SLVERR.
  - R_RESP: rvalid=1. rdata and rresp are held stable until rready=1, then return to R_IDLE.
  - Minimum is 4 cycles from AR handshake to R handshake.
- Collision rule
  - If R_ACCESS and W_ACCESS coincide with the same in-range idx, the read stays in R_ACCESS one extra cycle (ram_r_en=0 that cycle).
  - The read therefore returns the newly written, strobe-merged data.
  - Different addresses proceed in parallel.
- No transaction is ever dropped. Backpressure on B or R stalls only that path.

Optional Feature:
- Macro: AXI_RAM_ADDR_CHECK_EN.
- Defined:
  - Out-of-range accesses return SLVERR.
  - No RAM access is issued; rdata is 0.
- Undefined:
  - All responses are OKAY.
  - Out-of-range writes are still suppressed (ram_w_en=0).
  - Out-of-range reads return 0 without asserting ram_r_en.

Test Plan (defaults: DATA_WIDTH_BYTES=4, NUM_SLOTS=5):
- Reset:
  - Stimulus: rst_n=0 mid-write, after AW is captured and before W.
  - Required: all outputs 0 immediately; after release, no ram_w_en pulse; the next write behaves normally.
- Write with strobe:
  - Stimulus: AW 0x0 and W 0x11223344/strb 4'b1101 in the same cycle.
  - Required: one ram_w_en pulse with addr 0, data 0x11223344, strb 4'b1101; then bvalid with bresp=00.
- Write, W before AW:
  - Stimulus: W 0xFFFFFFFF/strb 4'hF to 0x4, with AW 3 cycles later.
  - Required: ram_w_en at addr 1; bresp=00.
- Read back:
  - Stimulus: AR 0x0, then AR 0x4, with rready held low 2 cycles on the first read.
  - Required: rdata stable while stalled; the two reads return RAM contents for slots 0 and 1; rresp=00.
- Out-of-range (macro defined):
  - Stimulus: write to 0x14 (idx 5), then read 0x14.
  - Required: no ram_w_en and no ram_r_en; bresp=10; rresp=10 with rdata=0.
  - With the macro undefined: responses are 00.
- Collision:
  - Stimulus: write 0xA5A5A5A5/strb 4'hF to 0x8 and a read of 0x8 reaching the ACCESS state in the same cycle.
  - Required: ram_r_en is delayed 1 cycle; rdata=0xA5A5A5A5.
